alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked arithmetic/logic unit for the datapath. It succeeds the fixed 4-bit, 2-select clocked ALU. It adds a configurable operand width, a wider opcode set and an iterative multi-cycle multiplier (plus an optional divider). It uses valid/ready flow control on both input and output. It sits between the register-file read stage and write-back and holds each result until the consumer takes it.

## Interface
- `W`, 4: operand width in bits; legal values are 2 to 32.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; asynchronous, active-high.
- `in_valid`  input  1  operands and opcode are presented.
- `in_ready`  output  1  unit accepts a new operation.
- `A`  input  W  operand A, unsigned.
- `B`  input  W  operand B, unsigned.
- `Sel`  input  3  opcode.
- `out_valid`  output  1  result is available.
- `out_ready`  input  1  consumer takes the result.
- `out`  output  2W  result.
- `cout`  output  1  carry or borrow.
- `err`  output  1  illegal opcode or divide-by-zero.

## Operation
- Opcodes:
  - 000 ADD
  - 001 SUB
  - 010 MUL
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 DIV
  - 111 reserved
- ADD:
  - `out` = {W'0, (A+B)[W-1:0]}.
  - `cout` = bit W of the sum.
- SUB:
  - `out` = {W'0, (A-B) mod 2^W}.
  - `cout` = 1 iff A < B (borrow).
- MUL: `out` = A*B, full 2W-bit unsigned product; `cout` = 0.
- AND/OR/XOR: bitwise result, zero-extended to 2W; `cout` = 0.
- DIV (when enabled):
  - `out[W-1:0]` = quotient, `out[2W-1:W]` = remainder; `cout` = 0.
  - If B = 0: quotient is all ones, remainder = A, `err` = 1.
- Reserved opcode: `out` = 0, `cout` = 0, `err` = 1.
- `err` = 0 for every other case.
- The FSM has three states: IDLE, BUSY, DONE.
  - IDLE: `in_ready` = 1. On `in_valid`, latch A, B and Sel.
    - Single-cycle opcodes go to DONE with the result registered.
    - MUL and DIV go to BUSY with the iteration counter = 0.
  - BUSY: one shift-add (MUL) or restore-subtract (DIV) step per cycle. After W steps, register the result and go to DONE.
  - DONE: `out_valid` = 1. On `out_ready`, go to IDLE.
- `in_ready` = 1 only in IDLE. There is no bypass: acceptance cannot coincide with result consumption.
- Input changes while not in IDLE are ignored, because operands are latched at acceptance.
- `out`, `cout` and `err` are held stable for the whole time `out_valid` = 1.
- Reset at any time, including mid-BUSY:
  - The state returns to IDLE and any partial result is discarded.
  - `out` = 0, `cout` = 0, `err` = 0, `out_valid` = 0, `in_ready` = 1 (in_ready goes high while reset is asserted).

## Timing
- The accept cycle is the edge where `in_valid` and `in_ready` are both 1.
- Single-cycle opcodes: `out_valid` rises at the next edge (latency 1).
- MUL/DIV: `out_valid` rises W+1 edges after acceptance.
- Consumption takes one cycle. With `out_valid` and `out_ready` both 1 at an edge, the next cycle has `in_ready` = 1.
- Peak throughput for single-cycle opcodes is one operation per 2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `ALU_SEQ_DIV_EN`.
- Defined: opcode 110 performs iterative restoring division in the shared iteration unit, with latency W+1.
- Undefined:
  - Opcode 110 is treated as reserved: `out` = 0, `err` = 1, latency 1.
  - No divider logic is synthesised.

## Structure
- Package `alu_pkg`:
  - opcode localparams (`OP_ADD` … `OP_RSV`)
  - FSM state enum (`ST_IDLE`, `ST_BUSY`, `ST_DONE`)
  - opcode-is-multicycle helper function
- Sub-module `alu_iter_unit`: W-step shift-add multiplier and (under the macro) restoring divider.
  - Interface: start, op, A, B, done, result.
  - The top-level FSM and the single-cycle datapath remain in `alu_seq`.

## Test plan (W = 4)
- ADD, A=9, B=10, `out_ready` held 1 → one cycle later `out` = 3, `cout` = 1, `err` = 0; `in_ready` high the cycle after.
- SUB, A=3, B=4 → `out` = 15, `cout` = 1.
- MUL, A=15, B=15 → `out_valid` rises exactly 5 edges after acceptance with `out` = 225; `in_ready` stays 0 throughout.
- Backpressure: AND, A=6, B=5, `out_ready` held 0 for 4 cycles → `out` = 4 held stable, `in_ready` = 0; release → IDLE next cycle.
- Reset asserted mid-MUL (step 2) → all outputs 0 immediately, `in_ready` = 1 after release; a following ADD 1+2 returns 3.
- With `ALU_SEQ_DIV_EN`:
  - 13/4 → `out` = 0x13 (q 3, r 1).
  - 7/0 → `out` = 0x7F, `err` = 1.
- Without `ALU_SEQ_DIV_EN`: opcode 110 → `out` = 0, `err` = 1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq datapath: opcodes, FSM states and the
// opcode classification helper. The optional divider is selected by the
// ALU_SEQ_DIV_EN macro; without it opcode 110 behaves as reserved.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for opcodes that run through the iterative unit.
  function automatic logic is_multicycle(input logic [2:0] op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// W-step iterative unit: shift-add multiplier and, when ALU_SEQ_DIV_EN is
// defined, a restoring divider sharing the same 2W-bit working register.
// done is asserted during the cycle whose closing edge completes step W;
// result is the value the working register takes at that edge.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] result
);

  localparam int CW = $clog2(W + 1);

  logic           busy;
  logic [CW-1:0]  cnt;
  // MUL: {partial high, remaining multiplier bits}; DIV: {remainder, quotient}.
  logic [2*W-1:0] work;
  // MUL: multiplicand; DIV: divisor.
  logic [W-1:0]   opnd;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] step;

`ifdef ALU_SEQ_DIV_EN
  logic           is_div;
  logic [W:0]     shifted;
  logic [W-1:0]   diff;
`else
  logic           unused_in;
  assign unused_in = ^{op, b};
`endif

  // One multiply or divide step computed from the current working register.
  always_comb begin
    mul_sum = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    step    = {mul_sum, work[W-1:1]};
`ifdef ALU_SEQ_DIV_EN
    shifted = {work[2*W-1:W], work[W-1]};
    diff    = shifted[W-1:0] - opnd;
    if (is_div) begin
      // Remainder stays below the divisor, so the low W bits are exact.
      if (shifted >= {1'b0, opnd}) step = {diff, work[W-2:0], 1'b1};
      else                         step = {shifted[W-1:0], work[W-2:0], 1'b0};
    end
`endif
  end

  assign done   = busy && (cnt == CW'(W - 1));
  assign result = step;

  // Load operands on start, then advance one step per cycle until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      work <= '0;
      opnd <= '0;
`ifdef ALU_SEQ_DIV_EN
      is_div <= 1'b0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
      is_div <= (op == OP_DIV);
      if (op == OP_DIV) begin
        opnd <= b;
        work <= {{W{1'b0}}, a};
      end else begin
        opnd <= a;
        work <= {{W{1'b0}}, b};
      end
`else
      opnd <= a;
      work <= {{W{1'b0}}, b};
`endif
    end else if (busy) begin
      work <= step;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ADD/SUB/logic ops plus iterative MUL (and DIV
// when ALU_SEQ_DIV_EN is defined). Handshake: an operation is accepted on an
// edge where in_valid && in_ready; a result is consumed on an edge where
// out_valid && out_ready; out/cout/err hold steady while out_valid is high.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [2:0]     Sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out,
  output logic           cout,
  output logic           err
);

  state_t         state;
  logic           accept;
  logic           iter_start;
  logic           iter_done;
  logic [2*W-1:0] iter_result;

  logic [2*W-1:0] sc_out;
  logic           sc_cout;
  logic           sc_err;
  logic [W:0]     sum_w;
  logic [W:0]     diff_w;

`ifdef ALU_SEQ_DIV_EN
  logic           div_zero;
`endif

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign accept     = in_valid && (state == ST_IDLE);
  assign iter_start = accept && is_multicycle(Sel);

  alu_iter_unit #(.W(W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .op     (Sel),
    .a      (A),
    .b      (B),
    .done   (iter_done),
    .result (iter_result)
  );

  // Single-cycle result; opcode 110 without the divider and 111 are reserved.
  always_comb begin
    sc_out  = '0;
    sc_cout = 1'b0;
    sc_err  = 1'b0;
    sum_w   = {1'b0, A} + {1'b0, B};
    diff_w  = {1'b0, A} - {1'b0, B};
    case (Sel)
      OP_ADD: begin
        sc_out  = {{W{1'b0}}, sum_w[W-1:0]};
        sc_cout = sum_w[W];
      end
      OP_SUB: begin
        sc_out  = {{W{1'b0}}, diff_w[W-1:0]};
        sc_cout = diff_w[W];
      end
      OP_AND:  sc_out = {{W{1'b0}}, A & B};
      OP_OR:   sc_out = {{W{1'b0}}, A | B};
      OP_XOR:  sc_out = {{W{1'b0}}, A ^ B};
      default: sc_err = 1'b1;
    endcase
  end

  // Control FSM and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      out   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_multicycle(Sel)) begin
              state <= ST_BUSY;
`ifdef ALU_SEQ_DIV_EN
              div_zero <= (Sel == OP_DIV) && (B == '0);
`endif
            end else begin
              state <= ST_DONE;
              out   <= sc_out;
              cout  <= sc_cout;
              err   <= sc_err;
            end
          end
        end
        ST_BUSY: begin
          if (iter_done) begin
            state <= ST_DONE;
            out   <= iter_result;
            cout  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            err   <= div_zero;
`else
            err   <= 1'b0;
`endif
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (W = 4). Expected values come from an arithmetic model of
// the opcode rules; latency is counted in edges with the accept edge as 1.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2:0]     Sel;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out;
  logic           cout;
  logic           err;

  int total;
  int bad;
  logic [2*W+1:0] exp_q[$];

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: returns {err, cout, out}.
  function automatic logic [2*W+1:0] model(input int a, input int b, input logic [2:0] sel);
    longint o;
    logic c, e;
    o = 0; c = 1'b0; e = 1'b0;
    case (sel)
      3'd0: begin o = (a + b) % M; c = (a + b) >= M; end
      3'd1: begin o = (a - b + M) % M; c = a < b; end
      3'd2: o = a * b;
      3'd3: o = a & b;
      3'd4: o = a | b;
      3'd5: o = a ^ b;
`ifdef ALU_SEQ_DIV_EN
      3'd6: begin
        if (b == 0) begin o = a * M + (M - 1); e = 1'b1; end
        else        o = (a % b) * M + (a / b);
      end
`endif
      default: e = 1'b1;
    endcase
    return {e, c, (2*W)'(o)};
  endfunction

  function automatic int model_lat(input logic [2:0] sel);
`ifdef ALU_SEQ_DIV_EN
    if (sel == 3'd2 || sel == 3'd6) return W + 1;
`else
    if (sel == 3'd2) return W + 1;
`endif
    return 1;
  endfunction

  // driver: one full transaction with optional backpressure
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] sel, input int hold);
    logic [2*W+1:0] exp;
    int lat;
    int edges;
    exp = model(int'(a), int'(b), sel);
    lat = model_lat(sel);
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; Sel = sel;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Sel = 3'($urandom);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL busy_in_ready: in_ready=%b required 0 at edge %0d", in_ready, edges);
      end
      @(posedge clk); #1;
      edges++;
    end
    total++;
    if (edges != lat) begin
      bad++; $display("FAIL latency: op=%0d edges=%0d required %0d", sel, edges, lat);
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin @(posedge clk); #1; end
      total++;
      if ({err, cout, out} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL result: op=%0d a=%0d b=%0d hold=%0d got err=%b cout=%b out=%h v=%b r=%b required err=%b cout=%b out=%h v=1 r=0",
                 sel, a, b, h, err, cout, out, out_valid, in_ready, exp[2*W+1], exp[2*W], exp[2*W-1:0]);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL consume: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Sel = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0 || cout !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_state: r=%b v=%b out=%h cout=%b err=%b required 1/0/0/0/0",
                      in_ready, out_valid, out, cout, err);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    do_op(4'd9,  4'd10, OP_ADD, 0);
    do_op(4'd3,  4'd4,  OP_SUB, 0);
    do_op(4'd15, 4'd15, OP_MUL, 0);
    do_op(4'd6,  4'd5,  OP_AND, 4);
    do_op(4'd13, 4'd4,  OP_DIV, 0);
    do_op(4'd7,  4'd0,  OP_DIV, 1);
    do_op(4'd5,  4'd9,  OP_RSV, 0);
    do_op(4'd0,  4'd0,  OP_SUB, 0);
    do_op(4'd15, 4'd1,  OP_ADD, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      do_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end
  endtask

  // Inputs held valid continuously with the consumer always ready:
  // one accept every two cycles, and values offered during DONE are ignored.
  task automatic test_back_to_back();
    logic [2*W+1:0] e;
    logic [2:0] sc_ops [5];
    sc_ops[0] = OP_ADD; sc_ops[1] = OP_SUB; sc_ops[2] = OP_AND;
    sc_ops[3] = OP_OR;  sc_ops[4] = OP_XOR;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      A = W'($urandom); B = W'($urandom); Sel = sc_ops[$urandom_range(0, 4)];
      exp_q.push_back(model(int'(A), int'(B), Sel));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || {err, cout, out} !== e) begin
        bad++; $display("FAIL b2b_result: i=%0d v=%b got %h required %h", i, out_valid, {err, cout, out}, e);
      end
      @(negedge clk);
      A = W'($urandom); B = W'($urandom); Sel = 3'($urandom);
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL b2b_idle: i=%0d in_ready=%b out_valid=%b required 1/0", i, in_ready, out_valid);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    in_valid = 1'b1; A = 4'd15; B = 4'd15; Sel = OP_MUL;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0 || cout !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL mid_reset: r=%b v=%b out=%h cout=%b err=%b required 1/0/0/0/0",
                      in_ready, out_valid, out, cout, err);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    do_op(4'd1, 4'd2, OP_ADD, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
